// File: rtl/mem_boot_pkg.sv
// Shared state encoding and default sizing for the boot loader.
// Imported by the top level and by the run-length timer.
package mem_boot_pkg;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_ADDR_W     = 9;
   localparam int DEF_RUN_CYCLES = 800;
   localparam int DEF_DUMP_WORDS = 50;
   localparam int TIMER_W        = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DUMP_RD,
      ST_DUMP_OUT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/mem_boot_loader_run_timer.sv
// Counts CPU run cycles from zero; expire_o pulses on the last cycle of the run.
module run_timer
   import mem_boot_pkg::*;
#(
   parameter int CYCLES = DEF_RUN_CYCLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic count_i,
   output logic expire_o
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(CYCLES - 1);

   logic [TIMER_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (count_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_boot_loader.sv
// Boot loader: streams a program into external memory, holds the CPU out of
// reset for a fixed run time, then streams back the first DUMP_WORDS words.
module mem_boot_loader
   import mem_boot_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int RUN_CYCLES = DEF_RUN_CYCLES,
   parameter int DUMP_WORDS = DEF_DUMP_WORDS
) (
   input  logic              Clk,
   input  logic              Clr,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cpu_rst_n,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W-1:0] LAST_DUMP = ADDR_W'(DUMP_WORDS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
   logic [ADDR_W-1:0] dump_ptr_q, dump_ptr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              ovf_q, ovf_d;
   logic              fresh_q, fresh_d;
   logic              timer_load;
   logic              timer_expire;
   logic              run_active;

   assign run_active = (state_q == ST_RUN);

   run_timer #(
      .CYCLES (RUN_CYCLES)
   ) u_run_timer (
      .clk_i    (Clk),
      .rst_ni   (Clr),
      .load_i   (timer_load),
      .count_i  (run_active),
      .expire_o (timer_expire)
   );

   always_comb begin
      state_d    = state_q;
      load_ptr_d = load_ptr_q;
      dump_ptr_d = dump_ptr_q;
      out_data_d = out_data_q;
      ovf_d      = ovf_q;
      fresh_d    = (state_q == ST_DUMP_RD);
      timer_load = 1'b0;
      in_ready   = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      out_valid  = 1'b0;
      out_data   = out_data_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_LOAD;
               load_ptr_d = '0;
               dump_ptr_d = '0;
               ovf_d      = 1'b0;
               timer_load = 1'b1;
            end
         end
         ST_LOAD: begin
            in_ready  = 1'b1;
            mem_addr  = load_ptr_q;
            mem_wdata = in_data;
            if (in_valid) begin
               mem_we = 1'b1;
               // The pointer parks on the top word instead of wrapping to 0.
               if (load_ptr_q != LAST_ADDR) begin
                  load_ptr_d = load_ptr_q + 1'b1;
               end
               if (in_last) begin
                  state_d = ST_RUN;
               end else if (load_ptr_q == LAST_ADDR) begin
                  ovf_d   = 1'b1;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (timer_expire) begin
               state_d = ST_DUMP_RD;
            end
         end
         ST_DUMP_RD: begin
            mem_re   = 1'b1;
            mem_addr = dump_ptr_q;
            state_d  = ST_DUMP_OUT;
         end
         ST_DUMP_OUT: begin
            out_valid = 1'b1;
            // Read data is only present on the first DUMP_OUT cycle; pass it
            // through then and hold the captured copy for any stall.
            if (fresh_q) begin
               out_data   = mem_rdata;
               out_data_d = mem_rdata;
            end
            if (out_ready) begin
               dump_ptr_d = dump_ptr_q + 1'b1;
               state_d    = (dump_ptr_q == LAST_DUMP) ? ST_DONE : ST_DUMP_RD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q    <= ST_IDLE;
         load_ptr_q <= '0;
         dump_ptr_q <= '0;
         out_data_q <= '0;
         ovf_q      <= 1'b0;
         fresh_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_ptr_q <= load_ptr_d;
         dump_ptr_q <= dump_ptr_d;
         out_data_q <= out_data_d;
         ovf_q      <= ovf_d;
         fresh_q    <= fresh_d;
      end
   end

   assign cpu_rst_n = Clr && run_active;
   assign out_addr  = dump_ptr_q;
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                      (state_q == ST_DUMP_RD) || (state_q == ST_DUMP_OUT);
   assign done      = (state_q == ST_DONE);
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: external memory harness, vector table, directed
// corner sequences and randomized loads checked against a reference model.
module tb_mem_boot_loader;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int RUNC  = 10;
   localparam int DUMPW = 4;

   logic          Clk = 1'b0;
   logic          Clr;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          mem_we;
   logic          mem_re;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          cpu_rst_n;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;
   logic          overflow;

   mem_boot_loader #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .RUN_CYCLES (RUNC),
      .DUMP_WORDS (DUMPW)
   ) dut (
      .Clk       (Clk),
      .Clr       (Clr),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .cpu_rst_n (cpu_rst_n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   always #5 Clk = ~Clk;

   // External synchronous memory: read data appears the cycle after mem_re.
   logic [DW-1:0] mem [DEPTH] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
   always @(posedge Clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   // Reference model state: what memory should hold after each load.
   logic [DW-1:0] ref_mem [DEPTH];

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ad_t;

   ad_t  wr_q[$];
   ad_t  dump_q[$];
   int   re_cnt = 0;
   int   run_cnt = 0;
   int   hold_err = 0;
   int   excl_err = 0;
   logic prev_stall = 1'b0;
   logic [AW-1:0] prev_a = '0;
   logic [DW-1:0] prev_d = '0;

   always @(negedge Clk) begin
      if (mem_we && mem_re) excl_err++;
      if (mem_we) wr_q.push_back('{a: mem_addr, d: mem_wdata});
      if (mem_re) re_cnt++;
      if (cpu_rst_n) run_cnt++;
      if (out_valid && out_ready) dump_q.push_back('{a: out_addr, d: out_data});
      if (prev_stall && (!out_valid || out_addr !== prev_a || out_data !== prev_d))
         hold_err++;
      prev_stall = out_valid && !out_ready;
      prev_a     = out_addr;
      prev_d     = out_data;
   end

   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_start();
      @(posedge Clk); #1;
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
   endtask

   typedef struct {
      int n;
      bit has_last;
      int gap;
      int stall_addr;
      int stall_len;
      bit pulse_start;
      int exp_acc;
      bit exp_ovf;
   } vec_t;

   vec_t          vecs[6];
   logic [DW-1:0] wd[$];

   task automatic run_txn(input logic [DW-1:0] d[$], input vec_t v, input bit rnd_ready);
      int  wr_base, re_base, run_base, dump_base, hold_base, excl_base;
      int  acc, stall_left;
      bit  ok, to, pulsed;
      wr_base   = wr_q.size();
      dump_base = dump_q.size();
      re_base   = re_cnt;
      run_base  = run_cnt;
      hold_base = hold_err;
      excl_base = excl_err;
      do_start();
      @(negedge Clk);
      check("start_busy", busy, 1);
      check("start_in_ready", in_ready, 1);
      check("start_done_clr", done, 0);
      check("start_ovf_clr", overflow, 0);
      @(posedge Clk); #1;
      acc = 0;
      for (int i = 0; i < v.n; i++) begin
         in_valid = 1'b1;
         in_data  = d[i];
         in_last  = v.has_last && (i == v.n - 1);
         @(negedge Clk);
         ok = in_ready;
         @(posedge Clk); #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
         if (!ok) break;
         acc++;
         repeat (v.gap) begin
            @(posedge Clk); #1;
         end
      end
      for (int i = 0; i < v.exp_acc && i < DEPTH; i++) ref_mem[i] = d[i];
      to = 1'b1;
      pulsed = 1'b0;
      stall_left = v.stall_len;
      for (int cyc = 0; cyc < 400; cyc++) begin
         start = 1'b0;
         if (out_valid && int'(out_addr) == v.stall_addr && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else if (rnd_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            out_ready = 1'b1;
         end
         if (v.pulse_start && !pulsed && out_valid) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
         @(negedge Clk);
         if (done) begin
            to = 1'b0;
            break;
         end
         @(posedge Clk); #1;
      end
      start = 1'b0;
      out_ready = 1'b1;
      if (to) begin
         check("done_timeout", 1, 0);
         Clr = 1'b0;
         @(negedge Clk);
         Clr = 1'b1;
         return;
      end
      check("accepted", acc, v.exp_acc);
      check("wr_count", wr_q.size() - wr_base, v.exp_acc);
      for (int i = 0; i < v.exp_acc && wr_base + i < wr_q.size(); i++) begin
         check("wr_addr", wr_q[wr_base + i].a, i);
         check("wr_data", wr_q[wr_base + i].d, d[i]);
      end
      check("overflow", overflow, v.exp_ovf);
      check("run_cycles", run_cnt - run_base, RUNC);
      check("dump_count", dump_q.size() - dump_base, DUMPW);
      for (int i = 0; i < DUMPW && dump_base + i < dump_q.size(); i++) begin
         check("dump_addr", dump_q[dump_base + i].a, i);
         check("dump_data", dump_q[dump_base + i].d, ref_mem[i]);
      end
      check("re_count", re_cnt - re_base, DUMPW);
      check("stall_hold", hold_err - hold_base, 0);
      check("we_re_excl", excl_err - excl_base, 0);
      check("done_flag", done, 1);
      check("busy_in_done", busy, 0);
   endtask

   initial begin
      vec_t rv;
      bit   ok;
      Clr = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hA0 + 8'(i);

      //                n  last gap stall len pulse acc ovf
      vecs[0] = '{4, 1, 0, -1, 0, 0, 4, 0};
      vecs[1] = '{4, 1, 3, -1, 0, 0, 4, 0};
      vecs[2] = '{9, 0, 0, -1, 0, 0, 8, 1};
      vecs[3] = '{4, 1, 0,  2, 5, 0, 4, 0};
      vecs[4] = '{1, 1, 1, -1, 0, 1, 1, 0};
      vecs[5] = '{8, 1, 0, -1, 0, 1, 8, 0};

      repeat (2) @(negedge Clk);
      check("rst_cpu_rst_n", cpu_rst_n, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_we_re", {mem_we, mem_re}, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_flags", {busy, done, overflow}, 0);
      check("rst_out_bus", {out_addr, out_data}, 0);
      @(posedge Clk); #1;
      Clr = 1'b1;
      repeat (3) @(negedge Clk);
      check("idle_busy", busy, 0);
      check("idle_in_ready", in_ready, 0);

      // Reset in the middle of RUN must pull cpu_rst_n low at once.
      do_start();
      in_valid = 1'b1;
      in_data  = 8'h5A;
      @(posedge Clk); #1;
      in_data  = 8'h5B;
      in_last  = 1'b1;
      @(posedge Clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      ref_mem[0] = 8'h5A;
      ref_mem[1] = 8'h5B;
      ok = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge Clk);
         if (cpu_rst_n) begin
            ok = 1'b1;
            break;
         end
      end
      check("run_entry", ok, 1);
      repeat (4) @(posedge Clk);
      #1;
      Clr = 1'b0;
      #1;
      check("midrun_cpu_rst_n", cpu_rst_n, 0);
      check("midrun_busy", busy, 0);
      @(posedge Clk); #1;
      Clr = 1'b1;
      repeat (3) @(negedge Clk);
      check("post_clr_idle", {busy, in_ready, cpu_rst_n}, 0);

      for (int v = 0; v < 6; v++) begin
         wd.delete();
         for (int i = 0; i < vecs[v].n; i++) wd.push_back(8'((i + 1) * 8'h11 + v));
         run_txn(wd, vecs[v], 1'b0);
      end

      for (int r = 0; r < 8; r++) begin
         rv.has_last    = ($urandom_range(0, 4) != 0);
         rv.n           = rv.has_last ? int'($urandom_range(1, DEPTH)) : int'($urandom_range(DEPTH, DEPTH + 2));
         rv.gap         = $urandom_range(0, 2);
         rv.stall_addr  = -1;
         rv.stall_len   = 0;
         rv.pulse_start = $urandom_range(0, 1);
         rv.exp_acc     = rv.has_last ? rv.n : DEPTH;
         rv.exp_ovf     = !rv.has_last;
         wd.delete();
         for (int i = 0; i < rv.n; i++) wd.push_back(8'($urandom));
         run_txn(wd, rv, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
